// File: rtl/sparse_frame_decimator.sv
// sparse_frame_decimator
//   Accepts frames of INPUT_LENGTH beats, keeps the beats selected by
//   KEEP_MASK (OUTPUT_LENGTH of them) into a ping/pong store, and replays
//   each completed frame on a valid/ready output with a last-beat marker.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_input_data   input beat
//   i_input_valid  input beat valid
//   o_input_ready  block can accept an input beat (registers only)
//   o_output_data  kept beat, zero when o_output_valid=0
//   o_output_valid output beat valid
//   o_output_last  high with the final kept beat of a frame
//   i_output_ready downstream accepts the output beat
module sparse_frame_decimator #(
    parameter int unsigned             WIDTH         = 96,
    parameter int unsigned             INPUT_LENGTH  = 11,
    parameter int unsigned             OUTPUT_LENGTH = 1,
    parameter logic [INPUT_LENGTH-1:0] KEEP_MASK     = {1'b1, {(INPUT_LENGTH-1){1'b0}}}
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_input_data,
    input  logic             i_input_valid,
    output logic             o_input_ready,
    output logic [WIDTH-1:0] o_output_data,
    output logic             o_output_valid,
    output logic             o_output_last,
    input  logic             i_output_ready
);

    localparam int unsigned IDX_W  = (INPUT_LENGTH > 1) ? $clog2(INPUT_LENGTH) : 1;
    localparam int unsigned SLOT_W = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;
    // Banks are sized to the full slot-index range so every index value is legal.
    localparam int unsigned DEPTH  = 1 << SLOT_W;
    localparam logic [IDX_W-1:0]  IN_LAST  = IDX_W'(INPUT_LENGTH - 1);
    localparam logic [SLOT_W-1:0] OUT_LAST = SLOT_W'(OUTPUT_LENGTH - 1);

    if (INPUT_LENGTH < 2) begin : g_bad_length
        $error("sparse_frame_decimator: INPUT_LENGTH must be at least 2");
    end
    if ($countones(KEEP_MASK) != int'(OUTPUT_LENGTH)) begin : g_bad_mask
        $error("sparse_frame_decimator: popcount(KEEP_MASK) must equal OUTPUT_LENGTH");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]  bank [2][DEPTH];
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              fill_sel;
    logic [IDX_W-1:0]  in_idx;
    logic [SLOT_W-1:0] wr_slot;
    logic              rd_sel;
    logic [SLOT_W-1:0] rd_idx;

    logic in_fire;
    logic out_fire;
    logic set_full;
    logic clr_full;

    // Control: one init cycle after reset before input is accepted.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_INIT) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        o_input_ready  = (state == ST_RUN) && !full[fill_sel];
        o_output_valid = full[rd_sel];
        o_output_last  = full[rd_sel] && (rd_idx == OUT_LAST);
        o_output_data  = full[rd_sel] ? bank[rd_sel][rd_idx] : '0;
    end

    assign in_fire  = i_input_valid && o_input_ready;
    assign out_fire = o_output_valid && i_output_ready;
    assign set_full = in_fire && (in_idx == IN_LAST);
    assign clr_full = out_fire && (rd_idx == OUT_LAST);

    // Set and clear are applied to separate bits so a frame completing on the
    // fill side and a frame draining on the read side in one cycle both land.
    always_comb begin
        full_next = full;
        if (set_full) begin
            full_next[fill_sel] = 1'b1;
        end
        if (clr_full) begin
            full_next[rd_sel] = 1'b0;
        end
    end

    // Fill side
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fill_sel <= 1'b0;
            in_idx   <= '0;
            wr_slot  <= '0;
        end else if (in_fire) begin
            if (in_idx == IN_LAST) begin
                in_idx   <= '0;
                wr_slot  <= '0;
                fill_sel <= !fill_sel;
            end else begin
                in_idx <= in_idx + 1'b1;
                if (KEEP_MASK[in_idx]) begin
                    wr_slot <= wr_slot + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (in_fire && KEEP_MASK[in_idx]) begin
            bank[fill_sel][wr_slot] <= i_input_data;
        end
    end

    // Read side
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rd_sel <= 1'b0;
            rd_idx <= '0;
            full   <= '0;
        end else begin
            full <= full_next;
            if (out_fire) begin
                if (rd_idx == OUT_LAST) begin
                    rd_idx <= '0;
                    rd_sel <= !rd_sel;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    // Filling a bank requires it empty, draining requires it full, so the
    // two updates can never target the same bank.
    assert property (@(posedge i_clock) disable iff (i_reset)
        !(set_full && clr_full && (fill_sel == rd_sel)));

endmodule

// File: tb/tb_sparse_frame_decimator.sv
module tb_sparse_frame_decimator;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // default configuration: 11 in, 1 out, keep beat 10
    logic [95:0] d_in_data, d_out_data;
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_last, d_out_ready;
    // 8 in, 3 out, mask 1000_0101
    logic [15:0] s_in_data, s_out_data;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_last, s_out_ready;
    // 4 in, 4 out, pass-through
    logic [15:0] p_in_data, p_out_data;
    logic        p_in_valid, p_in_ready, p_out_valid, p_out_last, p_out_ready;

    sparse_frame_decimator u_def (
        .i_clock(clk), .i_reset(rst),
        .i_input_data(d_in_data), .i_input_valid(d_in_valid), .o_input_ready(d_in_ready),
        .o_output_data(d_out_data), .o_output_valid(d_out_valid), .o_output_last(d_out_last),
        .i_output_ready(d_out_ready)
    );

    sparse_frame_decimator #(
        .WIDTH(16), .INPUT_LENGTH(8), .OUTPUT_LENGTH(3), .KEEP_MASK(8'b1000_0101)
    ) u_sel (
        .i_clock(clk), .i_reset(rst),
        .i_input_data(s_in_data), .i_input_valid(s_in_valid), .o_input_ready(s_in_ready),
        .o_output_data(s_out_data), .o_output_valid(s_out_valid), .o_output_last(s_out_last),
        .i_output_ready(s_out_ready)
    );

    sparse_frame_decimator #(
        .WIDTH(16), .INPUT_LENGTH(4), .OUTPUT_LENGTH(4), .KEEP_MASK(4'b1111)
    ) u_pass (
        .i_clock(clk), .i_reset(rst),
        .i_input_data(p_in_data), .i_input_valid(p_in_valid), .o_input_ready(p_in_ready),
        .o_output_data(p_out_data), .o_output_valid(p_out_valid), .o_output_last(p_out_last),
        .i_output_ready(p_out_ready)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Offset of the k-th kept beat within an 8-beat frame for mask 1000_0101.
    function automatic int kept_off(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 7;
        endcase
    endfunction

    // Sends n beats base, base+1, ... on the 8/3 instance; returns beats accepted.
    task automatic send_sel(input logic [15:0] base, input int n, output int acc);
        acc = 0;
        for (int c = 0; c < 4 * n + 20 && acc < n; c++) begin
            s_in_valid = 1'b1;
            s_in_data  = base + 16'(acc);
            if (s_in_ready) begin
                step;
                acc++;
            end else begin
                step;
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        tests++; if (d_in_ready !== 1'b0) begin fails++; $display("FAIL reset_d_ready actual=%b required=0", d_in_ready); end
        tests++; if (d_out_valid !== 1'b0) begin fails++; $display("FAIL reset_d_valid actual=%b required=0", d_out_valid); end
        tests++; if (d_out_last !== 1'b0) begin fails++; $display("FAIL reset_d_last actual=%b required=0", d_out_last); end
        tests++; if (d_out_data !== 96'd0) begin fails++; $display("FAIL reset_d_data actual=%h required=0", d_out_data); end
        tests++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0) begin fails++; $display("FAIL reset_s_ready_valid actual=%b%b required=00", s_in_ready, s_out_valid); end
        tests++; if (p_in_ready !== 1'b0 || p_out_valid !== 1'b0) begin fails++; $display("FAIL reset_p_ready_valid actual=%b%b required=00", p_in_ready, p_out_valid); end
        rst = 1'b0;
        tests++; if (d_in_ready !== 1'b0) begin fails++; $display("FAIL init_cycle_ready actual=%b required=0", d_in_ready); end
        step;
        tests++; if (d_in_ready !== 1'b1 || s_in_ready !== 1'b1 || p_in_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_init actual=%b%b%b required=111", d_in_ready, s_in_ready, p_in_ready);
        end
    endtask

    task automatic test_default_frames;
        int stalls;
        logic exp_valid;
        stalls = 0;
        d_out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 11; b++) begin
                d_in_valid = 1'b1;
                d_in_data  = 96'(f * 11 + b + 1);
                for (int w = 0; w < 20 && !d_in_ready; w++) begin
                    stalls++;
                    step;
                end
                step;
                exp_valid = (b == 10);
                tests++; if (d_out_valid !== exp_valid) begin
                    fails++; $display("FAIL def_valid f=%0d b=%0d actual=%b required=%b", f, b, d_out_valid, exp_valid);
                end
                if (b == 10) begin
                    tests++; if (d_out_data !== 96'(f * 11 + 11) || d_out_last !== 1'b1) begin
                        fails++; $display("FAIL def_data f=%0d actual=%0d/%b required=%0d/1", f, d_out_data, d_out_last, f * 11 + 11);
                    end
                end
            end
        end
        d_in_valid = 1'b0;
        tests++; if (stalls != 0) begin fails++; $display("FAIL def_no_stall actual=%0d required=0", stalls); end
    endtask

    task automatic test_select;
        int acc;
        int n;
        logic [15:0] ed;
        s_out_ready = 1'b1;
        send_sel(16'h0010, 8, acc);
        tests++; if (acc != 8) begin fails++; $display("FAIL sel_accept actual=%0d required=8", acc); end
        tests++; if (s_out_valid !== 1'b1) begin fails++; $display("FAIL sel_latency actual=%b required=1", s_out_valid); end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (s_out_valid) begin
                tests++;
                ed = 16'(16'h0010 + kept_off(n));
                if (n >= 3 || s_out_data !== ed || s_out_last !== (n == 2)) begin
                    fails++; $display("FAIL sel_out n=%0d actual=%h/%b required=%h/%b", n, s_out_data, s_out_last, ed, n == 2);
                end
                n++;
            end
            step;
        end
        tests++; if (n != 3) begin fails++; $display("FAIL sel_count actual=%0d required=3", n); end
    endtask

    task automatic test_backpressure;
        int sent;
        int rcv;
        logic in_fire;
        logic out_fire;
        logic [15:0] ed;
        sent = 0;
        rcv  = 0;
        s_out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            s_in_valid = (sent < 24);
            s_in_data  = 16'(16'h20 + (sent / 8) * 16 + sent % 8);
            in_fire    = s_in_valid && s_in_ready;
            step;
            if (in_fire) begin
                sent++;
                if (sent == 8) begin
                    tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_1st actual=%b required=1", s_in_ready); end
                end
                if (sent == 16) begin
                    tests++; if (s_in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_after_2nd actual=%b required=0", s_in_ready); end
                end
            end
        end
        tests++; if (sent != 16) begin fails++; $display("FAIL bp_accepted actual=%0d required=16", sent); end
        tests++; if (s_out_valid !== 1'b1 || s_out_data !== 16'h0020 || s_out_last !== 1'b0) begin
            fails++; $display("FAIL bp_held_out actual=%b/%h/%b required=1/0020/0", s_out_valid, s_out_data, s_out_last);
        end
        s_out_ready = 1'b1;
        for (int c = 0; c < 60 && rcv < 9; c++) begin
            s_in_valid = (sent < 24);
            s_in_data  = 16'(16'h20 + (sent / 8) * 16 + sent % 8);
            in_fire    = s_in_valid && s_in_ready;
            out_fire   = s_out_valid && s_out_ready;
            if (out_fire) begin
                ed = 16'(16'h20 + (rcv / 3) * 16 + kept_off(rcv % 3));
                tests++; if (s_out_data !== ed || s_out_last !== (rcv % 3 == 2)) begin
                    fails++; $display("FAIL bp_out n=%0d actual=%h/%b required=%h/%b", rcv, s_out_data, s_out_last, ed, rcv % 3 == 2);
                end
            end
            step;
            if (in_fire) sent++;
            if (out_fire) begin
                rcv++;
                if (rcv <= 3) begin
                    tests++; if (s_in_ready !== (rcv == 3)) begin
                        fails++; $display("FAIL bp_ready_return n=%0d actual=%b required=%b", rcv, s_in_ready, rcv == 3);
                    end
                end
            end
        end
        s_in_valid = 1'b0;
        tests++; if (rcv != 9 || sent != 24) begin fails++; $display("FAIL bp_totals actual=%0d/%0d required=9/24", rcv, sent); end
    endtask

    task automatic test_random;
        logic [15:0] q[$];
        logic [7:0]  msk;
        logic [15:0] cur;
        logic [15:0] ed;
        logic [15:0] prev_data;
        logic        prev_last;
        logic        prev_stall;
        logic        in_fire;
        logic        out_fire;
        int sent;
        int rcv;
        msk = 8'b1000_0101;
        sent = 0;
        rcv = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        cur = 16'($urandom);
        for (int c = 0; c < 20000 && rcv < 600; c++) begin
            s_in_valid  = (sent < 1600) && ($urandom_range(1, 0) == 1);
            s_in_data   = cur;
            s_out_ready = ($urandom_range(1, 0) == 1);
            if (prev_stall) begin
                tests++; if (s_out_valid !== 1'b1 || s_out_data !== prev_data || s_out_last !== prev_last) begin
                    fails++; $display("FAIL rnd_stable actual=%b/%h/%b required=1/%h/%b", s_out_valid, s_out_data, s_out_last, prev_data, prev_last);
                end
            end
            in_fire  = s_in_valid && s_in_ready;
            out_fire = s_out_valid && s_out_ready;
            if (out_fire) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rnd_unexpected actual=%h required=none", s_out_data);
                end else begin
                    ed = q.pop_front();
                    if (s_out_data !== ed || s_out_last !== (rcv % 3 == 2)) begin
                        fails++; $display("FAIL rnd_out n=%0d actual=%h/%b required=%h/%b", rcv, s_out_data, s_out_last, ed, rcv % 3 == 2);
                    end
                end
                rcv++;
            end
            prev_stall = s_out_valid && !s_out_ready;
            prev_data  = s_out_data;
            prev_last  = s_out_last;
            step;
            if (in_fire) begin
                if (msk[3'(sent % 8)]) q.push_back(cur);
                sent++;
                cur = 16'($urandom);
            end
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        tests++; if (rcv != 600 || q.size() != 0) begin fails++; $display("FAIL rnd_totals actual=%0d/%0d required=600/0", rcv, q.size()); end
    endtask

    task automatic test_reset_mid_frame;
        int acc;
        int n;
        logic [15:0] ed;
        s_out_ready = 1'b0;
        send_sel(16'h0060, 8, acc);
        send_sel(16'h0070, 5, acc);
        tests++; if (acc != 5 || s_out_valid !== 1'b1) begin fails++; $display("FAIL rm_setup actual=%0d/%b required=5/1", acc, s_out_valid); end
        rst = 1'b1;
        step;
        tests++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b0 || s_out_data !== 16'h0) begin
            fails++; $display("FAIL rm_in_reset actual=%b/%b/%h required=0/0/0000", s_out_valid, s_in_ready, s_out_data);
        end
        rst = 1'b0;
        tests++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b0) begin fails++; $display("FAIL rm_init actual=%b/%b required=0/0", s_out_valid, s_in_ready); end
        step;
        tests++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin fails++; $display("FAIL rm_after_init actual=%b/%b required=0/1", s_out_valid, s_in_ready); end
        s_out_ready = 1'b1;
        send_sel(16'h0050, 8, acc);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (s_out_valid) begin
                tests++;
                ed = 16'(16'h0050 + kept_off(n));
                if (n >= 3 || s_out_data !== ed || s_out_last !== (n == 2)) begin
                    fails++; $display("FAIL rm_out n=%0d actual=%h/%b required=%h/%b", n, s_out_data, s_out_last, ed, n == 2);
                end
                n++;
            end
            step;
        end
        tests++; if (n != 3) begin fails++; $display("FAIL rm_count actual=%0d required=3", n); end
    endtask

    task automatic test_passthrough;
        int sent;
        int rcv;
        int stalls;
        int first_c;
        int last_c;
        logic in_fire;
        logic out_fire;
        sent = 0;
        rcv = 0;
        stalls = 0;
        first_c = -1;
        last_c = -1;
        p_out_ready = 1'b1;
        for (int c = 0; c < 40 && rcv < 12; c++) begin
            p_in_valid = (sent < 12);
            p_in_data  = 16'(sent + 1);
            if (p_in_valid && !p_in_ready) stalls++;
            in_fire  = p_in_valid && p_in_ready;
            out_fire = p_out_valid && p_out_ready;
            if (out_fire) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                tests++; if (p_out_data !== 16'(rcv + 1) || p_out_last !== (rcv % 4 == 3)) begin
                    fails++; $display("FAIL pt_out n=%0d actual=%h/%b required=%h/%b", rcv, p_out_data, p_out_last, 16'(rcv + 1), rcv % 4 == 3);
                end
                rcv++;
            end
            step;
            if (in_fire) sent++;
        end
        p_in_valid = 1'b0;
        tests++; if (stalls != 0) begin fails++; $display("FAIL pt_no_stall actual=%0d required=0", stalls); end
        tests++; if (rcv != 12 || first_c != 4 || last_c != 15) begin
            fails++; $display("FAIL pt_throughput actual=%0d/%0d/%0d required=12/4/15", rcv, first_c, last_c);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        d_in_data = '0; d_in_valid = 1'b0; d_out_ready = 1'b0;
        s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        p_in_data = '0; p_in_valid = 1'b0; p_out_ready = 1'b0;
        test_reset;
        test_default_frames;
        test_select;
        test_backpressure;
        test_random;
        test_passthrough;
        test_reset_mid_frame;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sparse_frame_decimator.md
Name: sparse_frame_decimator

Overview:
- Parametrised successor to the fixed 11-in/1-out sparse E multiplier.
- Accepts frames of INPUT_LENGTH beats and keeps the beats selected by a compile-time KEEP_MASK (OUTPUT_LENGTH beats per frame).
- Double-buffers the kept beats in a ping/pong store and replays them on a valid/ready output, with a last-beat marker.
- Sits between LDPC/sparse-matrix stages wherever a fixed sparse column selection of a streamed frame is needed.

Parameters:
- WIDTH, 96, data width in bits.
- INPUT_LENGTH, 11, beats per input frame; must be at least 2.
- OUTPUT_LENGTH, 1, beats kept per frame; must equal popcount(KEEP_MASK) and satisfy 1 <= OUTPUT_LENGTH <= INPUT_LENGTH.
- KEEP_MASK, INPUT_LENGTH bits, default 1 << (INPUT_LENGTH-1); bit k=1 keeps input beat k of each frame.

Ports:
- i_clock  input  1  single clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_input_data  input  WIDTH  input beat.
- i_input_valid  input  1  input beat valid.
- o_input_ready  output  1  block can accept an input beat.
- o_output_data  output  WIDTH  kept beat; zero when o_output_valid=0.
- o_output_valid  output  1  output beat valid.
- o_output_last  output  1  high with the final kept beat of a frame.
- i_output_ready  input  1  downstream accepts the output beat.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge when valid & ready are both high, on either side.
- Storage: two banks (ping=0, pong=1), each OUTPUT_LENGTH x WIDTH, plus flags full[1:0].
- Fill-side registers:
  - fill_sel selects the bank being written.
  - in_idx counts 0..INPUT_LENGTH-1, width $clog2(INPUT_LENGTH), minimum 1 bit.
  - wr_slot counts 0..OUTPUT_LENGTH-1.
- Read-side registers: rd_sel selects the bank being read; rd_idx counts 0..OUTPUT_LENGTH-1.
- Reset (while i_reset=1):
  - All counters, selects and full flags go to 0; init flag is set.
  - Outputs are o_input_ready=0, o_output_valid=0, o_output_last=0, o_output_data=0.
  - Bank contents do not need to be cleared.
- Init cycle: one cycle after reset deassertion with o_input_ready=0, matching the existing ST_INIT convention; the init flag clears at the end of it.
- o_input_ready = !init & !full[fill_sel]. Combinational from registers only; never from i_input_valid.
- On each input transfer:
  - If KEEP_MASK[in_idx]=1, write bank[fill_sel][wr_slot] and increment wr_slot.
  - If in_idx = INPUT_LENGTH-1: set in_idx=0, wr_slot=0, full[fill_sel]=1, and toggle fill_sel. Otherwise increment in_idx.
- Read side:
  - o_output_valid = full[rd_sel].
  - o_output_data = bank[rd_sel][rd_idx] when valid, else 0.
  - o_output_last = o_output_valid & (rd_idx = OUTPUT_LENGTH-1).
- On each output transfer: if rd_idx = OUTPUT_LENGTH-1, set rd_idx=0, full[rd_sel]=0 and toggle rd_sel; otherwise increment rd_idx.
- Latency: the first kept beat of a frame is valid on the cycle after the edge that accepts the frame's final input beat.
- Simultaneous set of full[a] and clear of full[b] in the same cycle must both take effect. a=b is impossible by construction; assert on it in simulation.
- Throughput: with i_output_ready held high, the input never stalls, since OUTPUT_LENGTH <= INPUT_LENGTH.
- Both banks full:
  - o_input_ready=0; input beats are held off and never dropped.
  - Ready returns the cycle after the bank at fill_sel is drained.
- Output stalls (i_output_ready=0 while valid): o_output_data and o_output_last hold stable.
- Wrap-around: in_idx, wr_slot and rd_idx wrap exactly at their maxima and never reach illegal values.
- Reset mid-frame: partial frames and pending output are discarded. After the init cycle, the next accepted beat is beat 0 of a new frame.
- Elaboration errors:
  - popcount(KEEP_MASK) != OUTPUT_LENGTH.
  - INPUT_LENGTH < 2.

Test Plan:
- Defaults, 11 beats valued 1..11 sent back to back, output ready high -> one output beat of 11 with last=1, valid on the cycle after beat 11 is accepted. Three frames produce 11, 22, 33 with no input stall.
- INPUT_LENGTH=8, OUTPUT_LENGTH=3, KEEP_MASK=8'b1000_0101, beats 0x10..0x17 -> output 0x10, 0x12, 0x17 in order, with last only on 0x17.
- Output ready held low, three frames offered -> two frames accepted. o_input_ready drops after the 2nd frame's final beat and rises the cycle after the first output frame drains. No data lost.
- Random valid/ready at 50% each over 200 frames (mask 8'b1000_0101) -> output equals the software model of kept beats. Data and last stay stable whenever stalled.
- Reset asserted after beat 5 of a frame with one frame pending output -> valid=0 and ready=0 through the init cycle. The next frame's kept beats are output correctly, and no stale data appears.
- OUTPUT_LENGTH=INPUT_LENGTH=4, mask 4'b1111 -> pass-through with last on every 4th beat and full throughput.
